// File: rtl/jtpopeye_pkg.sv
// Shared JTPOPEYE definitions: palette PROM sizes and the PROM loader
// state encoding, plus small helpers for stepping through the load order.
package jtpopeye_pkg;

    localparam int PROM_SZ_4A = 32;
    localparam int PROM_SZ_5B = 256;
    localparam int PROM_SZ_5A = 256;
    localparam int PROM_SZ_3A = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L4A  = 3'd1,
        ST_L5B  = 3'd2,
        ST_L5A  = 3'd3,
        ST_L3A  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } ld_state_t;

    function automatic logic is_load(input ld_state_t s);
        return (s == ST_L4A) || (s == ST_L5B) || (s == ST_L5A) || (s == ST_L3A);
    endfunction

    // Stream order is 4a, 5b, 5a, 3a; the stage after 3a is DONE.
    function automatic ld_state_t next_stage(input ld_state_t s);
        case (s)
            ST_L4A:  return ST_L5B;
            ST_L5B:  return ST_L5A;
            ST_L5A:  return ST_L3A;
            ST_L3A:  return ST_DONE;
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/jtpopeye_prom_loader.sv
// Palette PROM loader: takes the byte-serial download stream and writes it
// into the 4a, 5b, 5a and 3a colour PROMs in that order over a shared
// address/data bus with one write strobe per PROM.
//
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   dl_start                pulse: new palette image begins (always wins)
//   dl_valid, dl_data       download byte strobe and data
//   dl_end                  pulse: downloader finished sending
//   prog_addr, prom_din     shared PROM write address / data
//   prom_{4a,5b,5a,3a}_we   one-cycle write strobes
//   loading, done, error    load status (done/error sticky until dl_start)
//
// state | meaning
// IDLE  | no image loaded since reset
// L4A   | receiving background PROM 4a bytes
// L5B   | receiving object PROM 5b bytes
// L5A   | receiving object PROM 5a bytes
// L3A   | receiving text PROM 3a bytes
// DONE  | all four PROMs written
// ERR   | image was short (dl_end early) or long (extra byte)
module jtpopeye_prom_loader
    import jtpopeye_pkg::*;
#(
    parameter int SZ_4A = PROM_SZ_4A,
    parameter int SZ_5B = PROM_SZ_5B,
    parameter int SZ_5A = PROM_SZ_5A,
    parameter int SZ_3A = PROM_SZ_3A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dl_start,
    input  logic       dl_valid,
    input  logic [7:0] dl_data,
    input  logic       dl_end,
    output logic [7:0] prog_addr,
    output logic [7:0] prom_din,
    output logic       prom_4a_we,
    output logic       prom_5b_we,
    output logic       prom_5a_we,
    output logic       prom_3a_we,
    output logic       loading,
    output logic       done,
    output logic       error
);

    ld_state_t  state, state_nx;
    logic [8:0] cnt, cnt_nx;
    logic [8:0] cur_last;
    logic       accept;

    always_comb begin
        cur_last = '0;
        case (state)
            ST_L4A:  cur_last = 9'(SZ_4A - 1);
            ST_L5B:  cur_last = 9'(SZ_5B - 1);
            ST_L5A:  cur_last = 9'(SZ_5A - 1);
            ST_L3A:  cur_last = 9'(SZ_3A - 1);
            default: cur_last = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        if (dl_start) begin
            state_nx = ST_L4A;
            cnt_nx   = '0;
        end else if (is_load(state)) begin
            if (dl_valid) begin
                accept = 1'b1;
                if (cnt == cur_last) begin
                    cnt_nx   = '0;
                    state_nx = next_stage(state);
                end else begin
                    cnt_nx = cnt + 9'd1;
                end
            end
            // An early dl_end still lets a coincident byte be written; only a
            // byte that completes 3a turns the short image into a good one.
            if (dl_end && state_nx != ST_DONE)
                state_nx = ST_ERR;
        end else if (state == ST_DONE && dl_valid) begin
            state_nx = ST_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prog_addr  <= '0;
            prom_din   <= '0;
            prom_4a_we <= 1'b0;
            prom_5b_we <= 1'b0;
            prom_5a_we <= 1'b0;
            prom_3a_we <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            prom_4a_we <= accept && state == ST_L4A;
            prom_5b_we <= accept && state == ST_L5B;
            prom_5a_we <= accept && state == ST_L5A;
            prom_3a_we <= accept && state == ST_L3A;
            if (accept) begin
                prog_addr <= cnt[7:0];
                prom_din  <= dl_data;
            end
            // loading covers the final 3a strobe; done follows one cycle later
            // so it only rises once that write has landed.
            loading <= is_load(state_nx) || (state_nx == ST_DONE && state != ST_DONE);
            done    <= state == ST_DONE && state_nx == ST_DONE;
            error   <= state_nx == ST_ERR;
        end
    end

endmodule

// File: tb/tb_jtpopeye_prom_loader.sv
// Randomised bench for the palette PROM loader against a byte-count model.
module tb_jtpopeye_prom_loader;
    import jtpopeye_pkg::*;

    localparam int TOTAL = PROM_SZ_4A + PROM_SZ_5B + PROM_SZ_5A + PROM_SZ_3A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dl_start = 1'b0;
    logic       dl_valid = 1'b0;
    logic [7:0] dl_data = 8'h00;
    logic       dl_end = 1'b0;
    logic [7:0] prog_addr, prom_din;
    logic       prom_4a_we, prom_5b_we, prom_5a_we, prom_3a_we;
    logic       loading, done, error;

    jtpopeye_prom_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dl_start   (dl_start),
        .dl_valid   (dl_valid),
        .dl_data    (dl_data),
        .dl_end     (dl_end),
        .prog_addr  (prog_addr),
        .prom_din   (prom_din),
        .prom_4a_we (prom_4a_we),
        .prom_5b_we (prom_5b_we),
        .prom_5a_we (prom_5a_we),
        .prom_3a_we (prom_3a_we),
        .loading    (loading),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: tracks only how many bytes of the image were taken.
    typedef enum int {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
    mode_t      mode = M_IDLE;
    int         nacc = 0;
    logic [3:0] exp_we = '0;
    logic [7:0] exp_addr = '0, exp_din = '0;
    logic       exp_loading = 0, exp_done = 0, exp_error = 0;
    logic [3:0] last_obs_we = '0;
    logic [7:0] last_obs_addr = '0;

    function automatic void locate(input int n, output int idx, output int addr);
        if (n < PROM_SZ_4A) begin
            idx = 0; addr = n;
        end else if (n < PROM_SZ_4A + PROM_SZ_5B) begin
            idx = 1; addr = n - PROM_SZ_4A;
        end else if (n < PROM_SZ_4A + PROM_SZ_5B + PROM_SZ_5A) begin
            idx = 2; addr = n - PROM_SZ_4A - PROM_SZ_5B;
        end else begin
            idx = 3; addr = n - PROM_SZ_4A - PROM_SZ_5B - PROM_SZ_5A;
        end
    endfunction

    task automatic model_reset();
        mode = M_IDLE; nacc = 0; exp_we = '0;
        exp_loading = 0; exp_done = 0; exp_error = 0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d, input logic e);
        int idx, addr;
        exp_we = '0;
        if (s) begin
            mode = M_LOAD; nacc = 0;
            exp_loading = 1; exp_done = 0; exp_error = 0;
        end else begin
            case (mode)
                M_LOAD: begin
                    if (v) begin
                        locate(nacc, idx, addr);
                        exp_we[idx] = 1'b1;
                        exp_addr = addr[7:0];
                        exp_din = d;
                        nacc++;
                    end
                    if (nacc == TOTAL) mode = M_DONE;
                    else if (e) begin
                        mode = M_ERR; exp_error = 1; exp_loading = 0; exp_done = 0;
                    end
                end
                M_DONE: begin
                    if (v) begin
                        mode = M_ERR; exp_error = 1; exp_done = 0; exp_loading = 0;
                    end else begin
                        exp_done = 1; exp_loading = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [3:0] we;
        we = {prom_3a_we, prom_5a_we, prom_5b_we, prom_4a_we};
        check_eq("we", 32'(we), 32'(exp_we));
        check_eq("loading", 32'(loading), 32'(exp_loading));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("error", 32'(error), 32'(exp_error));
        if (exp_we != 0) begin
            check_eq("addr", 32'(prog_addr), 32'(exp_addr));
            check_eq("din", 32'(prom_din), 32'(exp_din));
        end
        if (we != 0) begin
            last_obs_we = we;
            last_obs_addr = prog_addr;
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and checks the result.
    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic e);
        dl_start = s; dl_valid = v; dl_data = d; dl_end = e;
        model_step(s, v, d, e);
        @(posedge clk);
        @(negedge clk);
        dl_start = 0; dl_valid = 0; dl_end = 0;
        check_outputs();
    endtask

    // Sends nbytes image bytes (value = index mod 256) with dl_valid duty in %.
    task automatic send_bytes(input int nbytes, input int duty);
        int sent = 0;
        while (sent < nbytes) begin
            if ($urandom_range(0, 99) < duty) begin
                step(0, 1, 8'(sent), 0);
                sent++;
            end else begin
                step(0, 0, 8'($urandom), 0);
            end
        end
    endtask

    task automatic full_load(input int duty);
        step(1, 0, 8'h00, 0);
        send_bytes(TOTAL, duty);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_addr", 32'(prog_addr), 32'h0);
        check_eq("rst_din", 32'(prom_din), 32'h0);
        rst_n = 1'b1;
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h5a, 1);            // idle: valid and end ignored

        full_load(100);
        full_load(50);

        step(0, 1, 8'hee, 0);            // image long
        step(0, 0, 8'h00, 0);
        full_load(70);

        step(1, 0, 8'h00, 0);            // image short
        send_bytes(100, 100);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h11, 0);            // ignored in ERR
        check_eq("short_last_we", 32'(last_obs_we), 32'h2);
        check_eq("short_last_addr", 32'(last_obs_addr), 32'd67);

        step(1, 0, 8'h00, 0);            // restart at byte 300
        send_bytes(300, 100);
        step(1, 1, 8'hab, 0);
        send_bytes(TOTAL, 100);
        step(0, 1, 8'h33, 1);            // long, with coincident end
        step(0, 0, 8'h00, 0);

        step(1, 0, 8'h00, 0);            // async reset mid-5a
        send_bytes(300, 100);
        dl_valid = 1; dl_data = 8'h77;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_we", 32'({prom_3a_we, prom_5a_we, prom_5b_we, prom_4a_we}), 32'h0);
        check_eq("arst_addr", 32'(prog_addr), 32'h0);
        check_eq("arst_din", 32'(prom_din), 32'h0);
        check_eq("arst_status", 32'({loading, done, error}), 32'h0);
        dl_valid = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1, 8'(i), 0);
        full_load(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
